// File: rtl/timer_pkg.sv
// Shared types and constants for the timer controller.
// Holds the FSM state encoding and the default counter width.
package timer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_unit.sv
// WIDTH-bit up counter with synchronous clear and enable.
// Clear wins over enable; reset behaves like clear.
module count_unit #(
  parameter int WIDTH = timer_pkg::WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (enable) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable one-shot / periodic timer with pause and abort.
// The FSM drives count_unit; tick, done and err are registered pulses.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] period,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state
);

  // start is a single-cycle request with no ready: it is accepted only when
  // the FSM sits in IDLE or DONE and period is non-zero, otherwise dropped.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q;
  logic             m_q;
  logic             capture;
  logic             cnt_clr, cnt_en;
  logic             busy_q, tick_q, done_q, err_q;
  logic             tick_d, done_d, err_d;
  logic             at_terminal;

  assign at_terminal = (count == p_q - WIDTH'(1));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (period != '0) begin
            capture = 1'b1;
            cnt_clr = 1'b1;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (at_terminal) begin
          cnt_clr = 1'b1;
          tick_d  = 1'b1;
          if (!m_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      PAUSE: begin
        // Release only re-enters RUN; the next edge does the counting.
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN) || (state_d == PAUSE);
      tick_q  <= tick_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (capture) begin
        p_q <= period;
        m_q <= periodic;
      end
    end
  end

  count_unit #(.WIDTH(WIDTH)) u_count (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .q      (count)
  );

  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with immediate-assertion checks.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, periodic, pause, abort;
  logic [W-1:0] period;
  logic         busy, tick, done, err;
  logic [W-1:0] count;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .period   (period),
    .periodic (periodic),
    .pause    (pause),
    .abort    (abort),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .err      (err),
    .count    (count),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input state_t st, input int cnt,
                         input int bsy, input int tk, input int dn, input int er);
    chk({tag, ".state"}, int'(state), int'(st));
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".busy"},  int'(busy),  bsy);
    chk({tag, ".tick"},  int'(tick),  tk);
    chk({tag, ".done"},  int'(done),  dn);
    chk({tag, ".err"},   int'(err),   er);
  endtask

  task automatic go(input int p, input logic m);
    start = 1'b1; period = W'(p); periodic = m;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; period = '0; periodic = 1'b0;
    pause = 1'b0; abort = 1'b0;
    step();
    chk_all("reset", IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // One-shot, P=4
    go(4, 1'b0);
    chk_all("os4_e0", RUN, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all("os4_run", RUN, k, 1, 0, 0, 0);
    end
    step();
    chk_all("os4_e4", DONE, 0, 0, 1, 1, 0);
    step();
    chk_all("os4_idle", IDLE, 0, 0, 0, 0, 0);

    // Periodic, P=3, ticks after edges 3, 6, 9
    go(3, 1'b1);
    chk_all("per3_e0", RUN, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_all("per3", RUN, k % 3, 1, (k % 3 == 0) ? 1 : 0, 0, 0);
    end
    abort = 1'b1;
    step();
    chk_all("per3_abort", IDLE, 0, 0, 0, 0, 0);
    abort = 1'b0;

    // Pause sampled at edges 3 and 4, released at edge 5
    go(5, 1'b0);
    step(); chk("pz_e1.count", int'(count), 1);
    step(); chk("pz_e2.count", int'(count), 2);
    pause = 1'b1;
    step(); chk_all("pz_e3", PAUSE, 2, 1, 0, 0, 0);
    step(); chk_all("pz_e4", PAUSE, 2, 1, 0, 0, 0);
    pause = 1'b0;
    step(); chk_all("pz_e5", RUN, 2, 1, 0, 0, 0);
    step(); chk_all("pz_e6", RUN, 3, 1, 0, 0, 0);
    step(); chk_all("pz_e7", RUN, 4, 1, 0, 0, 0);
    step(); chk_all("pz_e8", DONE, 0, 0, 1, 1, 0);
    step(); chk_all("pz_idle", IDLE, 0, 0, 0, 0, 0);

    // Pause at terminal count defers expiry
    go(2, 1'b0);
    step(); chk_all("tpz_e1", RUN, 1, 1, 0, 0, 0);
    pause = 1'b1;
    step(); chk_all("tpz_e2", PAUSE, 1, 1, 0, 0, 0);
    pause = 1'b0;
    step(); chk_all("tpz_e3", RUN, 1, 1, 0, 0, 0);
    step(); chk_all("tpz_e4", DONE, 0, 0, 1, 1, 0);
    step(); chk_all("tpz_idle", IDLE, 0, 0, 0, 0, 0);

    // period=0 rejected, then start while busy ignored
    go(0, 1'b1);
    chk_all("err_e0", IDLE, 0, 0, 0, 0, 1);
    step();
    chk_all("err_e1", IDLE, 0, 0, 0, 0, 0);
    go(3, 1'b0);
    start = 1'b1; period = W'(9); periodic = 1'b1;
    step(); chk_all("ign_e1", RUN, 1, 1, 0, 0, 0);
    step(); chk_all("ign_e2", RUN, 2, 1, 0, 0, 0);
    start = 1'b0;
    step(); chk_all("ign_e3", DONE, 0, 0, 1, 1, 0);
    step(); chk_all("ign_idle", IDLE, 0, 0, 0, 0, 0);

    // abort + pause together at count=2
    go(5, 1'b1);
    step(); step();
    chk("ap_pre.count", int'(count), 2);
    abort = 1'b1; pause = 1'b1;
    step(); chk_all("ap_abort", IDLE, 0, 0, 0, 0, 0);
    step(); chk_all("ap_idle_noeff", IDLE, 0, 0, 0, 0, 0);
    abort = 1'b0; pause = 1'b0;

    // Reset during PAUSE, then start accepted on first edge out of reset
    go(5, 1'b1);
    step();
    pause = 1'b1;
    step(); chk_all("rp_pause", PAUSE, 1, 1, 0, 0, 0);
    reset = 1'b1;
    step(); chk_all("rp_reset", IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0; pause = 1'b0;
    go(2, 1'b0);
    chk_all("rp_start", RUN, 0, 1, 0, 0, 0);
    step(); step();
    chk_all("rp_done", DONE, 0, 0, 1, 1, 0);
    step();

    // Maximum period 255, periodic
    go(255, 1'b1);
    for (int k = 1; k <= 253; k++) step();
    chk_all("max_e253", RUN, 253, 1, 0, 0, 0);
    step(); chk_all("max_e254", RUN, 254, 1, 0, 0, 0);
    step(); chk_all("max_e255", RUN, 0, 1, 1, 0, 0);
    for (int k = 256; k <= 509; k++) step();
    chk_all("max_e509", RUN, 254, 1, 0, 0, 0);
    step(); chk_all("max_e510", RUN, 0, 1, 1, 0, 0);
    abort = 1'b1;
    step(); abort = 1'b0;

    // P=1 periodic: tick every cycle, count stays 0
    go(1, 1'b1);
    chk_all("p1_e0", RUN, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all("p1", RUN, 0, 1, 1, 0, 0);
    end
    abort = 1'b1;
    step(); chk_all("p1_abort", IDLE, 0, 0, 0, 0, 0);
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
